triple_word_serializer: RTL and testbench
=========================================

TRIPLE_WORD_SERIALIZER -- requirements
Module: triple_word_serializer

Interface
REQ-001 Parameter: p_width, 8, width in bits of each data word.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rstN  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  a three-word group is offered on inpdata_1..3.
REQ-005 Port: in_ready  output  1  the block accepts the offered group this cycle.
REQ-006 Port: inpdata_1, inpdata_2, inpdata_3  input  p_width each  words of the group.
REQ-007 Port: out_valid  output  1  outp_data holds a valid word.
REQ-008 Port: out_ready  input  1  the downstream stage accepts the word this cycle.
REQ-009 Port: outp_data  output  p_width  current serialized word.
REQ-010 Port: outp_idx  output  2  index of the current word: 0, 1 or 2.
REQ-011 Port: outp_last  output  1  high when outp_idx == 2.
REQ-012 Port: busy  output  1  high when any word of a captured group is still unsent.

Function
REQ-013 A group SHALL be accepted only on a cycle where in_valid && in_ready; it is captured into a 3 x p_width hold register.
REQ-014 The FSM SHALL have four states, IDLE, W1, W2 and W3, and SHALL leave IDLE to W1 on acceptance.
REQ-015 A word SHALL be transferred only on a cycle where out_valid && out_ready.
REQ-016 A transfer SHALL advance the FSM W1->W2, W2->W3 and W3->IDLE, or W3->W1 if a new group is accepted in the same cycle.
REQ-017 out_valid SHALL be high exactly in W1, W2 and W3; outp_idx SHALL be 0, 1 and 2 in those states, with outp_data = word 1, 2 and 3.
REQ-018 in_ready SHALL equal (state==IDLE) || (state==W3 && out_ready); this combinational path from out_ready is intended.
REQ-019 Latency: for a group accepted at edge k, word 1 SHALL be presented in the cycle after edge k.
REQ-020 With out_ready held high, the throughput SHALL be one group per three cycles with no bubble between groups.
REQ-021 While out_valid && !out_ready, outp_data, outp_idx and outp_last SHALL hold stable.
REQ-022 Input words SHALL be ignored when no acceptance occurs, including in_valid high in W1 or W2.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 On rstN low the state SHALL become IDLE immediately, without waiting for a clock edge.
REQ-025 Reset values SHALL be: out_valid 0, outp_idx 0, outp_last 0, outp_data 0, busy 0, in_ready 1 (the last while rstN is high).
REQ-026 A reset during W1, W2 or W3 SHALL discard the pending group, and no partial word SHALL appear after release.
REQ-027 The first acceptance SHALL be possible on the first rising edge after rstN deasserts.

Configuration
REQ-028 When the macro TRIPLE_SER_PARITY_EN is defined, the block SHALL add the port outp_parity (output, 1 bit), equal to the XOR reduction of outp_data, qualified by out_valid and reset to 0.
REQ-029 When TRIPLE_SER_PARITY_EN is undefined, the outp_parity port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 The package triple_ser_pkg SHALL hold the state enum typedef (IDLE, W1, W2, W3) and the index constants IDX_W1=0, IDX_W2=1 and IDX_W3=2.
REQ-031 The 3-word capture register with load enable SHALL be the sub-module triple_hold_reg, parameterized by p_width.
REQ-032 The FSM, the handshake logic and the output mux SHALL reside in triple_word_serializer.

Verification
REQ-033 Single group: inputs 0x11, 0x22, 0x33 with out_ready=1 -> outputs 0x11, 0x22, 0x33 on three consecutive cycles starting one cycle after acceptance, idx 0/1/2, outp_last on 0x33 only.
REQ-034 Back-to-back groups: in_valid held high, groups A=(1,2,3) and B=(4,5,6) -> outputs 1,2,3,4,5,6 contiguous, and in_ready is high on the cycle word 3 is transferred.
REQ-035 Backpressure: out_ready=0 for 4 cycles while word 2 (0x22) is shown -> 0x22/idx 1 held stable, in_ready=0, no word lost or duplicated.
REQ-036 Reset mid-group: rstN pulled low between clock edges while in W2 -> out_valid drops to 0 at once, and after release no words from the aborted group appear.
REQ-037 Ignored input: in_valid pulsed with (0xAA, 0xBB, 0xCC) while in W1 -> the pulse is not accepted and the current group is output unchanged.
REQ-038 With TRIPLE_SER_PARITY_EN defined: word 0x07 -> outp_parity=1; word 0x03 -> outp_parity=0.

Source files
------------

// File: rtl/triple_ser_pkg.sv
// ============================================================================
// triple_ser_pkg : FSM state encoding and word-index constants shared by the
//                  triple-word serializer and its bench-facing sub-modules.
// Revision 1.0
// ============================================================================
`default_nettype none

package triple_ser_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      W1   = 2'd1,
      W2   = 2'd2,
      W3   = 2'd3
   } state_t;

   localparam logic [1:0] IDX_W1 = 2'd0;
   localparam logic [1:0] IDX_W2 = 2'd1;
   localparam logic [1:0] IDX_W3 = 2'd2;

endpackage : triple_ser_pkg

`default_nettype wire

// File: rtl/triple_hold_reg.sv
// ============================================================================
// triple_hold_reg : three-word capture register with a shared load enable.
// Revision 1.0
// ============================================================================
`default_nettype none

module triple_hold_reg #(
   parameter int p_width = 8
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               load,
   input  logic [p_width-1:0] word1_in,
   input  logic [p_width-1:0] word2_in,
   input  logic [p_width-1:0] word3_in,
   output logic [p_width-1:0] word1_out,
   output logic [p_width-1:0] word2_out,
   output logic [p_width-1:0] word3_out
);

   logic [p_width-1:0] word1_q, word1_d;
   logic [p_width-1:0] word2_q, word2_d;
   logic [p_width-1:0] word3_q, word3_d;

   always_comb begin
      word1_d = word1_q;
      word2_d = word2_q;
      word3_d = word3_q;
      if (load) begin
         word1_d = word1_in;
         word2_d = word2_in;
         word3_d = word3_in;
      end
   end

   // Clearing on reset guarantees an aborted group can never leak out later.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         word1_q <= '0;
         word2_q <= '0;
         word3_q <= '0;
      end else begin
         word1_q <= word1_d;
         word2_q <= word2_d;
         word3_q <= word3_d;
      end
   end

   assign word1_out = word1_q;
   assign word2_out = word2_q;
   assign word3_out = word3_q;

endmodule : triple_hold_reg

`default_nettype wire

// File: rtl/triple_word_serializer.sv
// ============================================================================
// triple_word_serializer : accepts a 3-word group and emits it one word per
//                          transfer. Optional outp_parity via TRIPLE_SER_PARITY_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module triple_word_serializer
   import triple_ser_pkg::*;
#(
   parameter int p_width = 8
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [p_width-1:0] inpdata_1,
   input  logic [p_width-1:0] inpdata_2,
   input  logic [p_width-1:0] inpdata_3,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [p_width-1:0] outp_data,
   output logic [1:0]         outp_idx,
   output logic               outp_last,
`ifdef TRIPLE_SER_PARITY_EN
   output logic               outp_parity,
`endif
   output logic               busy
);

   state_t state_q, state_d;
   logic   accept;
   logic [p_width-1:0] word1, word2, word3;

   // W3 can hand over to a new group in the same cycle its last word leaves.
   assign in_ready = (state_q == IDLE) || ((state_q == W3) && out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != IDLE);

   triple_hold_reg #(
      .p_width(p_width)
   ) u_hold (
      .clk      (clk),
      .rstN     (rstN),
      .load     (accept),
      .word1_in (inpdata_1),
      .word2_in (inpdata_2),
      .word3_in (inpdata_3),
      .word1_out(word1),
      .word2_out(word2),
      .word3_out(word3)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = W1;
         W1:      if (out_ready) state_d = W2;
         W2:      if (out_ready) state_d = W3;
         W3:      if (out_ready) state_d = accept ? W1 : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Outputs decode straight from state so an async reset clears them at once.
   always_comb begin
      out_valid = 1'b0;
      outp_idx  = IDX_W1;
      outp_data = '0;
      case (state_q)
         W1: begin
            out_valid = 1'b1;
            outp_idx  = IDX_W1;
            outp_data = word1;
         end
         W2: begin
            out_valid = 1'b1;
            outp_idx  = IDX_W2;
            outp_data = word2;
         end
         W3: begin
            out_valid = 1'b1;
            outp_idx  = IDX_W3;
            outp_data = word3;
         end
         default: ;
      endcase
   end

   assign outp_last = (outp_idx == IDX_W3);

`ifdef TRIPLE_SER_PARITY_EN
   assign outp_parity = out_valid & (^outp_data);
`endif

endmodule : triple_word_serializer

`default_nettype wire

// File: tb/tb_triple_word_serializer.sv
// ============================================================================
// tb_triple_word_serializer : scoreboard bench for triple_word_serializer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_triple_word_serializer;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] inpdata_1 = 8'h00;
   logic [7:0] inpdata_2 = 8'h00;
   logic [7:0] inpdata_3 = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] outp_data;
   logic [1:0] outp_idx;
   logic       outp_last;
   logic       busy;
`ifdef TRIPLE_SER_PARITY_EN
   logic       outp_parity;
`endif

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_data_q[$];
   logic [1:0] exp_idx_q[$];
   logic [7:0] mon_d;
   logic [1:0] mon_i;
   logic       mon_bad;

   always #5 clk = ~clk;

   triple_word_serializer #(.p_width(8)) dut (
      .clk       (clk),
      .rstN      (rstN),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inpdata_1 (inpdata_1),
      .inpdata_2 (inpdata_2),
      .inpdata_3 (inpdata_3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .outp_data (outp_data),
      .outp_idx  (outp_idx),
      .outp_last (outp_last),
`ifdef TRIPLE_SER_PARITY_EN
      .outp_parity(outp_parity),
`endif
      .busy      (busy)
   );

   task automatic push_group(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      exp_data_q.push_back(a); exp_idx_q.push_back(2'd0);
      exp_data_q.push_back(b); exp_idx_q.push_back(2'd1);
      exp_data_q.push_back(c); exp_idx_q.push_back(2'd2);
   endtask

   task automatic drive_group(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      in_valid  = 1'b1;
      inpdata_1 = a;
      inpdata_2 = b;
      inpdata_3 = c;
   endtask

   // Every word that crosses the output handshake is popped and compared here.
   always @(negedge clk) begin
      if (rstN && out_valid && out_ready) begin
         checks++;
         if (exp_data_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra_word: got data=%h idx=%0d, expected no word", outp_data, outp_idx);
         end else begin
            mon_d = exp_data_q.pop_front();
            mon_i = exp_idx_q.pop_front();
            mon_bad = (outp_data !== mon_d) || (outp_idx !== mon_i) || (outp_last !== (mon_i == 2'd2));
`ifdef TRIPLE_SER_PARITY_EN
            mon_bad = mon_bad || (outp_parity !== (^mon_d));
`endif
            if (mon_bad) begin
               errors++;
               $display("FAIL sb_word: got data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                        outp_data, outp_idx, outp_last, mon_d, mon_i, (mon_i == 2'd2));
            end
         end
      end
   end

   task automatic check_drained(input string name);
      checks++;
      if (exp_data_q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_drained: pending=%0d out_valid=%b busy=%b, expected 0 0 0",
                  name, exp_data_q.size(), out_valid, busy);
      end
      exp_data_q.delete();
      exp_idx_q.delete();
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || outp_idx !== 2'd0 || outp_last !== 1'b0 ||
          outp_data !== 8'h00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got valid=%b idx=%0d last=%b data=%h busy=%b, expected all 0",
                  out_valid, outp_idx, outp_last, outp_data, busy);
      end
      @(negedge clk);
      rstN = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
      end
   endtask

   // Called right after reset release: acceptance must happen on the first edge.
   task automatic test_single();
      drive_group(8'h11, 8'h22, 8'h33);
      push_group(8'h11, 8'h22, 8'h33);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || outp_data !== 8'h11 || outp_idx !== 2'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_latency: got valid=%b data=%h idx=%0d busy=%b, expected 1 11 0 1",
                  out_valid, outp_data, outp_idx, busy);
      end
      @(negedge clk);
      checks++;
      if (outp_data !== 8'h22 || outp_last !== 1'b0) begin
         errors++;
         $display("FAIL single_word2: got data=%h last=%b, expected 22 0", outp_data, outp_last);
      end
      @(negedge clk);
      checks++;
      if (outp_data !== 8'h33 || outp_idx !== 2'd2 || outp_last !== 1'b1) begin
         errors++;
         $display("FAIL single_word3: got data=%h idx=%0d last=%b, expected 33 2 1",
                  outp_data, outp_idx, outp_last);
      end
      @(negedge clk);
      check_drained("single");
   endtask

   task automatic test_back_to_back();
      drive_group(8'h01, 8'h02, 8'h03);
      push_group(8'h01, 8'h02, 8'h03);
      @(posedge clk);
      #1;
      drive_group(8'h04, 8'h05, 8'h06);
      push_group(8'h04, 8'h05, 8'h06);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_contiguous: cycle %0d got out_valid=%b, expected 1", i, out_valid);
         end
         if (i == 2) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_in_ready_w3: got %b, expected 1", in_ready);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      check_drained("b2b");
   endtask

   task automatic test_backpressure();
      drive_group(8'h11, 8'h22, 8'h33);
      push_group(8'h11, 8'h22, 8'h33);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || outp_data !== 8'h22 || outp_idx !== 2'd1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d got valid=%b data=%h idx=%0d in_ready=%b, expected 1 22 1 0",
                     i, out_valid, outp_data, outp_idx, in_ready);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_drained("bp");
   endtask

   task automatic test_reset_mid();
      drive_group(8'h51, 8'h52, 8'h53);
      exp_data_q.push_back(8'h51);
      exp_idx_q.push_back(2'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rstN = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || outp_data !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid_async: got valid=%b busy=%b data=%h, expected 0 0 00",
                  out_valid, busy, outp_data);
      end
      @(negedge clk);
      rstN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_leak: cycle %0d got out_valid=%b data=%h, expected 0",
                     i, out_valid, outp_data);
         end
      end
      check_drained("rst_mid");
   endtask

   task automatic test_ignored();
      drive_group(8'h61, 8'h62, 8'h63);
      push_group(8'h61, 8'h62, 8'h63);
      @(posedge clk);
      #1;
      drive_group(8'hAA, 8'hBB, 8'hCC);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ign_in_ready_w1: got %b, expected 0", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_drained("ignored");
   endtask

`ifdef TRIPLE_SER_PARITY_EN
   task automatic test_parity();
      drive_group(8'h07, 8'h03, 8'h00);
      push_group(8'h07, 8'h03, 8'h00);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (outp_parity !== 1'b1) begin
         errors++;
         $display("FAIL parity_07: got %b, expected 1", outp_parity);
      end
      @(negedge clk);
      checks++;
      if (outp_parity !== 1'b0) begin
         errors++;
         $display("FAIL parity_03: got %b, expected 0", outp_parity);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (outp_parity !== 1'b0) begin
         errors++;
         $display("FAIL parity_idle: got %b, expected 0", outp_parity);
      end
      check_drained("parity");
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_ignored();
`ifdef TRIPLE_SER_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_triple_word_serializer

`default_nettype wire
